// File: rtl/inst_fetch.sv
// inst_fetch: PC plus direct-mapped one-word-per-line I-cache feeding issue,
// with miss handling against the memory controller and static JAL prediction.
module inst_fetch #(
  parameter int          ICACHE_IDX_W = 6,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong_flag,
  input  logic [31:0] jump_target,
  output logic        inst_IF_req,
  output logic [31:0] inst_IF_addr,
  input  logic        inst_IF_flag,
  input  logic [31:0] inst_IF,
  input  logic        issue_stall,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pred_pc
);
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                  r_state, w_state_nxt;
  logic [31:0]             r_pc, w_pc_nxt;
  logic [LINES-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [31:0]             r_data [LINES];
  logic [ICACHE_IDX_W-1:0] w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic [31:0]             w_line, w_jal_imm, w_npc;
  logic                    w_hit, w_fill, w_fire;

  assign w_idx        = r_pc[ICACHE_IDX_W+1:2];
  assign w_tag        = r_pc[31:ICACHE_IDX_W+2];
  assign w_line       = r_data[w_idx];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_jal_imm    = {{12{w_line[31]}}, w_line[19:12], w_line[20], w_line[30:21], 1'b0};
  assign w_npc        = r_pc + ((w_line[6:0] == 7'b1101111) ? w_jal_imm : 32'd4);
  // A returning word is captured even during a redirect or while frozen by rdy=0
  assign w_fill       = (r_state == MISS) && inst_IF_flag;
  assign w_fire       = rdy && !jump_wrong_flag && (r_state == IDLE) && !issue_stall && w_hit;
  assign inst_IF_req  = (r_state == MISS);
  assign inst_IF_addr = r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (rdy && jump_wrong_flag) begin
      w_state_nxt = IDLE;
      w_pc_nxt    = jump_target;
    end else if (w_fill) begin
      w_state_nxt = IDLE;
    end else if (rdy && (r_state == IDLE) && !issue_stall) begin
      w_state_nxt = w_hit ? IDLE : MISS;
      w_pc_nxt    = w_hit ? w_npc : r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_fill) r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_idx] <= inst_IF;
      r_tag[w_idx]  <= w_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid   <= 1'b0;
      if_inst    <= '0;
      if_pc      <= '0;
      if_pred_pc <= '0;
    end else begin
      if_valid <= w_fire;
      if (w_fire) begin
        if_inst    <= w_line;
        if_pc      <= r_pc;
        if_pred_pc <= w_npc;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vectors and corner-case sequences for inst_fetch.
module tb_inst_fetch;
  logic        clk = 0, rst = 0, rdy = 1, jump_wrong_flag = 0, inst_IF_flag = 0, issue_stall = 0;
  logic [31:0] jump_target = 0, inst_IF = 0;
  logic        inst_IF_req, if_valid;
  logic [31:0] inst_IF_addr, if_inst, if_pc, if_pred_pc;
  int          n_chk = 0, n_err = 0;
  logic [31:0] mem [logic [31:0]];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] pred;
  } vec_t;
  vec_t tbl [7];

  inst_fetch #(.ICACHE_IDX_W(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong_flag(jump_wrong_flag), .jump_target(jump_target),
    .inst_IF_req(inst_IF_req), .inst_IF_addr(inst_IF_addr), .inst_IF_flag(inst_IF_flag), .inst_IF(inst_IF),
    .issue_stall(issue_stall), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pred_pc(if_pred_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h00000013;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] t);
    jump_wrong_flag = 1;
    jump_target     = t;
    cyc();
    jump_wrong_flag = 0;
  endtask

  // Acts as the memory controller (3-cycle latency) until an instruction issues
  task automatic serve(input string nm, input logic [31:0] epc, input logic [31:0] ew, input logic [31:0] ep);
    int lat = 0;
    bit ok  = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (inst_IF_req) begin
        lat++;
        if (lat >= 3) begin
          inst_IF_flag = 1;
          inst_IF      = rd(inst_IF_addr);
          lat          = 0;
        end
      end
      cyc();
      inst_IF_flag = 0;
      ok = if_valid;
    end
    chk({nm, "_valid"}, {31'b0, ok}, 32'd1);
    chk({nm, "_pc"}, if_pc, epc);
    chk({nm, "_inst"}, if_inst, ew);
    chk({nm, "_pred"}, if_pred_pc, ep);
  endtask

  initial begin
    tbl[0] = '{32'h00000200, 32'h00000013, 32'h00000204};
    tbl[1] = '{32'h00000300, 32'h0200006F, 32'h00000320};
    tbl[2] = '{32'h00000400, 32'hFFDFF06F, 32'h000003FC};
    tbl[3] = '{32'hFFFFFFFC, 32'h00000013, 32'h00000000};
    tbl[4] = '{32'h00000500, 32'h0000006F, 32'h00000500};
    tbl[5] = '{32'h00000600, 32'h0000006B, 32'h00000604};
    tbl[6] = '{32'hFFFFFFF0, 32'h0200006F, 32'h00000010};
    foreach (tbl[i]) mem[tbl[i].pc] = tbl[i].word;
    mem[32'h0]  = 32'h00000013;
    mem[32'h4]  = 32'h00100093;
    mem[32'h8]  = 32'h00200113;
    mem[32'hC]  = 32'h00300193;
    mem[32'h10] = 32'h0200006F;
    mem[32'h40] = 32'h00400213;

    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, if_valid}, 0);
    chk("rst_req", {31'b0, inst_IF_req}, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_pred", if_pred_pc, 0);
    chk("rst_addr", inst_IF_addr, 0);
    rst = 1;

    cyc();
    chk("cold_req", {31'b0, inst_IF_req}, 1);
    chk("cold_addr", inst_IF_addr, 0);
    inst_IF_flag = 1;
    inst_IF      = mem[32'h0];
    cyc();
    inst_IF_flag = 0;
    chk("cold_req_drop", {31'b0, inst_IF_req}, 0);
    chk("cold_valid_early", {31'b0, if_valid}, 0);
    cyc();
    chk("cold_valid", {31'b0, if_valid}, 1);
    chk("cold_inst", if_inst, 32'h00000013);
    chk("cold_pc", if_pc, 0);
    chk("cold_pred", if_pred_pc, 4);

    serve("seq4", 32'h4, mem[32'h4], 32'h8);
    serve("seq8", 32'h8, mem[32'h8], 32'hC);
    serve("seqC", 32'hC, mem[32'hC], 32'h10);
    serve("jal10", 32'h10, 32'h0200006F, 32'h30);
    cyc();
    chk("jal_req", {31'b0, inst_IF_req}, 1);
    chk("jal_addr", inst_IF_addr, 32'h30);

    redirect(32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("hit_valid", {31'b0, if_valid}, 1);
      chk("hit_pc", if_pc, 32'(4 * k));
      chk("hit_req", {31'b0, inst_IF_req}, 0);
    end

    redirect(32'h0);
    cyc();
    chk("stall_pre_pc", if_pc, 0);
    issue_stall = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_valid", {31'b0, if_valid}, 0);
      chk("stall_addr", inst_IF_addr, 32'h4);
    end
    issue_stall = 0;
    cyc();
    chk("stall_resume_valid", {31'b0, if_valid}, 1);
    chk("stall_resume_pc", if_pc, 32'h4);

    redirect(32'h40);
    cyc();
    chk("rw_req", {31'b0, inst_IF_req}, 1);
    chk("rw_addr", inst_IF_addr, 32'h40);
    inst_IF_flag    = 1;
    inst_IF         = mem[32'h40];
    jump_wrong_flag = 1;
    jump_target     = 32'h100;
    cyc();
    inst_IF_flag    = 0;
    jump_wrong_flag = 0;
    chk("rw_valid0", {31'b0, if_valid}, 0);
    cyc();
    chk("rw_valid1", {31'b0, if_valid}, 0);
    chk("rw_req2", {31'b0, inst_IF_req}, 1);
    chk("rw_addr2", inst_IF_addr, 32'h100);
    serve("rw100", 32'h100, 32'h13, 32'h104);
    redirect(32'h40);
    cyc();
    chk("rw_line_valid", {31'b0, if_valid}, 1);
    chk("rw_line_pc", if_pc, 32'h40);
    chk("rw_line_inst", if_inst, 32'h00400213);

    redirect(32'h0);
    cyc();
    chk("conf_req", {31'b0, inst_IF_req}, 1);
    chk("conf_addr", inst_IF_addr, 0);
    serve("conf0", 32'h0, 32'h13, 32'h4);
    redirect(32'h100);
    serve("conf100", 32'h100, 32'h13, 32'h104);
    redirect(32'h0);
    cyc();
    chk("conf_req2", {31'b0, inst_IF_req}, 1);
    chk("conf_addr2", inst_IF_addr, 0);

    rdy = 0;
    cyc();
    chk("rdy_req_hold", {31'b0, inst_IF_req}, 1);
    inst_IF_flag = 1;
    inst_IF      = mem[32'h0];
    cyc();
    inst_IF_flag = 0;
    chk("rdy_fill_req", {31'b0, inst_IF_req}, 0);
    chk("rdy_valid", {31'b0, if_valid}, 0);
    cyc();
    chk("rdy_frozen_valid", {31'b0, if_valid}, 0);
    chk("rdy_frozen_addr", inst_IF_addr, 0);
    rdy = 1;
    cyc();
    chk("rdy_resume_valid", {31'b0, if_valid}, 1);
    chk("rdy_resume_pc", if_pc, 0);

    for (int i = 0; i < 7; i++) begin
      redirect(tbl[i].pc);
      serve($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].word, tbl[i].pred);
    end

    redirect(32'h800);
    cyc();
    chk("rstm_req_pre", {31'b0, inst_IF_req}, 1);
    rst = 0;
    #1;
    chk("rstm_req", {31'b0, inst_IF_req}, 0);
    chk("rstm_addr", inst_IF_addr, 0);
    chk("rstm_pc", if_pc, 0);
    @(negedge clk);
    rst = 1;
    redirect(32'h40);
    cyc();
    chk("rstm_inval_valid", {31'b0, if_valid}, 0);
    chk("rstm_inval_req", {31'b0, inst_IF_req}, 1);
    chk("rstm_inval_addr", inst_IF_addr, 32'h40);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
